// File: rtl/dm_responder.sv
// ---------------------------------------------------------------------------
// dm_responder
// Single-port data-memory responder for a simple CPU load/store interface.
// A request is accepted in IDLE, waits WAIT_CYCLES cycles in ACCESS, then
// completes with a one-cycle rsp_valid pulse in RESP. Storage is an array of
// 2**DEPTH_LOG2 little-endian 32-bit words, cleared by reset.
//
// Request/response handshake: a request transfers on a rising edge where
// req_valid = 1 and req_ready = 1 (req_ready is high only in IDLE); request
// inputs are don't-care at all other times. rsp_valid is a single-cycle
// pulse that cannot be stalled; rsp_rdata and rsp_err stay valid until the
// next response overwrites them.
//
// Optional feature macro: DM_ALIGN_CHECK_EN
//   defined   : misaligned word/half accesses and req_type = 3 complete with
//               rsp_err = 1, rsp_rdata = 0 and no storage update.
//   undefined : low address bits below the access size are ignored,
//               req_type = 3 behaves as a word access, rsp_err stays 0.
//
// DEPTH_LOG2 must be in 1..29 so that some upper address bits remain.
// ---------------------------------------------------------------------------
module dm_responder #(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_type,
   input  logic        req_sext,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  o_dbg_state
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   // Address bits that matter: word index plus the byte-lane bits.
   localparam int AW    = DEPTH_LOG2 + 2;

   // FSM encoding (also visible on o_dbg_state).
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   // Access size encoding of req_type.
   localparam logic [1:0] T_WORD = 2'd0;
   localparam logic [1:0] T_HALF = 2'd1;
   localparam logic [1:0] T_BYTE = 2'd2;

   // Value of the wait counter on the last ACCESS cycle.
   localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [1:0]    r_state;
   logic [3:0]    r_cnt;

   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_wdata;
   logic [1:0]    r_type;
   logic          r_sext;

   logic [31:0]   r_rdata;
   logic          r_err;

   logic [31:0]   r_mem [DEPTH];

   // ------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------
   logic                  w_accept;
   logic                  w_enter_resp;
   logic [1:0]            w_state_nxt;
   logic [3:0]            w_cnt_nxt;

   logic                  w_op_we;
   logic [AW-1:0]         w_op_addr;
   logic [31:0]           w_op_wdata;
   logic [1:0]            w_op_type;
   logic                  w_op_sext;

   logic [DEPTH_LOG2-1:0] w_idx;
   logic [1:0]            w_lane;
   logic                  w_err;
   logic [3:0]            w_be;
   logic [31:0]           w_wdata_lane;
   logic [31:0]           w_rd_word;
   logic [15:0]           w_rd_half;
   logic [7:0]            w_rd_byte;
   logic [31:0]           w_load_data;
   logic                  w_mem_we;

   // Upper address bits alias onto the same storage and are never used.
   logic                  w_unused_addr;
   assign w_unused_addr = &{1'b0, req_addr[31:AW]};

   assign w_accept = req_valid && (r_state == S_IDLE);

   // Select the operation being executed: with zero wait states the access
   // happens on the acceptance edge itself, so the live request inputs are
   // used while in IDLE; otherwise the captured copy is used.
   always_comb begin
      if (r_state == S_IDLE) begin
         w_op_we    = req_we;
         w_op_addr  = req_addr[AW-1:0];
         w_op_wdata = req_wdata;
         w_op_type  = req_type;
         w_op_sext  = req_sext;
      end else begin
         w_op_we    = r_we;
         w_op_addr  = r_addr;
         w_op_wdata = r_wdata;
         w_op_type  = r_type;
         w_op_sext  = r_sext;
      end
   end

   // Next-state and wait-counter logic; also flags the storage access edge.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_enter_resp = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = 4'd0;
            if (w_accept) begin
               if (WAIT_CYCLES == 0) begin
                  w_state_nxt  = S_RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  w_state_nxt = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            if (r_cnt == LAST_WAIT) begin
               w_state_nxt  = S_RESP;
               w_cnt_nxt    = 4'd0;
               w_enter_resp = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   assign w_idx  = w_op_addr[AW-1:2];
   assign w_lane = w_op_addr[1:0];

   // Alignment / size error detection.
`ifdef DM_ALIGN_CHECK_EN
   always_comb begin
      case (w_op_type)
         T_WORD:  w_err = (w_lane != 2'd0);
         T_HALF:  w_err = w_lane[0];
         T_BYTE:  w_err = 1'b0;
         default: w_err = 1'b1;
      endcase
   end
`else
   assign w_err = 1'b0;
`endif

   // Store lane enables. The store data is replicated across the lanes so
   // the enable mask alone places it in the right position.
   always_comb begin
      case (w_op_type)
         T_HALF: begin
            w_be         = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata_lane = {2{w_op_wdata[15:0]}};
         end
         T_BYTE: begin
            w_be         = 4'b0001 << w_lane;
            w_wdata_lane = {4{w_op_wdata[7:0]}};
         end
         default: begin
            w_be         = 4'b1111;
            w_wdata_lane = w_op_wdata;
         end
      endcase
   end

   assign w_rd_word = r_mem[w_idx];
   assign w_rd_half = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];
   assign w_rd_byte = w_rd_word[{w_lane, 3'b000} +: 8];

   // Load lane extraction with sign or zero extension.
   always_comb begin
      case (w_op_type)
         T_HALF:  w_load_data = {{16{w_op_sext & w_rd_half[15]}}, w_rd_half};
         T_BYTE:  w_load_data = {{24{w_op_sext & w_rd_byte[7]}}, w_rd_byte};
         default: w_load_data = w_rd_word;
      endcase
   end

   assign w_mem_we = w_enter_resp && w_op_we && !w_err;

   // ------------------------------------------------------------------
   // Sequential logic
   // ------------------------------------------------------------------

   // FSM state and wait counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Capture the request on acceptance; held until the next acceptance.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= 32'd0;
         r_type  <= T_WORD;
         r_sext  <= 1'b0;
      end else if (w_accept) begin
         r_we    <= req_we;
         r_addr  <= req_addr[AW-1:0];
         r_wdata <= req_wdata;
         r_type  <= req_type;
         r_sext  <= req_sext;
      end
   end

   // Response data/error, loaded on the edge entering RESP and held after.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else if (w_enter_resp) begin
         r_rdata <= (w_op_we || w_err) ? 32'd0 : w_load_data;
         r_err   <= w_err;
      end
   end

   // Storage: cleared by reset, byte-enabled write on the edge entering RESP.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 32'd0;
         end
      end else if (w_mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_wdata_lane[8*b +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign req_ready   = (r_state == S_IDLE);
   assign rsp_valid   = (r_state == S_RESP);
   assign rsp_rdata   = r_rdata;
   assign rsp_err     = r_err;
   assign o_dbg_state = r_state;

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10: log2 of the number of 32-bit words of storage.
REQ-002 Parameter WAIT_CYCLES, default 2: access wait states, range 0..15.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: the reset is synchronous and active-low.
REQ-005 Port req_valid, input, 1: CPU request valid.
REQ-006 Port req_ready, output, 1: the responder can accept a request.
REQ-007 Port req_we, input, 1: 1 = store, 0 = load.
REQ-008 Port req_addr, input, 32: byte address.
REQ-009 Port req_wdata, input, 32: store data, right-aligned.
REQ-010 Port req_type, input, 2: access size; 0 = word, 1 = half, 2 = byte, 3 = reserved.
REQ-011 Port req_sext, input, 1: 1 = sign-extend loads, 0 = zero-extend loads.
REQ-012 Port rsp_valid, output, 1: one-cycle completion pulse.
REQ-013 Port rsp_rdata, output, 32: load result.
REQ-014 Port rsp_err, output, 1: access error flag, qualified by rsp_valid.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS and RESP.
- IDLE: req_ready = 1. req_valid = 1 moves to ACCESS, or to RESP when WAIT_CYCLES = 0.
- ACCESS: counts WAIT_CYCLES cycles, then moves to RESP.
- RESP: rsp_valid = 1 for exactly one cycle, then returns to IDLE.
REQ-016 req_ready SHALL be 1 only in IDLE. A request is accepted on a cycle where req_valid = 1 and req_ready = 1.
REQ-017 On acceptance, the block SHALL register req_we, req_addr, req_wdata, req_type and req_sext. Inputs are ignored until the next IDLE.
REQ-018 rsp_valid SHALL assert exactly WAIT_CYCLES+1 cycles after the acceptance edge. The response cannot be backpressured.
REQ-019 The word index SHALL be addr[DEPTH_LOG2+1:2]. Higher address bits are ignored, so addresses wrap and alias.
REQ-020 Byte lanes SHALL be little-endian:
- Byte accesses select the lane with addr[1:0].
- Half accesses select the half with addr[1].
REQ-021 Stores SHALL modify only the selected lanes, using the low bits of the registered wdata. Stores commit on the edge that enters RESP.
REQ-022 Loads SHALL read storage on the edge entering RESP. The result is the selected byte or half, extended per the registered sext flag. Word loads return the full word.
REQ-023 On a store, rsp_rdata SHALL be 0.
REQ-024 rsp_rdata and rsp_err SHALL hold their values until the next RESP.
REQ-025 A load that immediately follows a store to the same address SHALL return the newly stored data.

Reset
REQ-026 While reset = 0 at a clock edge, the block SHALL:
- set the FSM to IDLE and the wait counter to 0;
- drive rsp_valid = 0, rsp_rdata = 0 and rsp_err = 0;
- clear every storage word to 0.
REQ-027 Reset SHALL take priority over all other activity. An in-flight access is abandoned, and a store is not committed even on its commit edge.
REQ-028 req_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-029 Macro DM_ALIGN_CHECK_EN enables alignment checking.
- Defined: the following are errors: a word access with addr[1:0] != 0, a half access with addr[0] != 0, and req_type = 3. An error access does not write storage, returns rsp_rdata = 0 and rsp_err = 1, and has normal latency.
- Undefined: word accesses ignore addr[1:0], half accesses ignore addr[0], req_type 3 is treated as word, and rsp_err is tied to 0.

Verification
REQ-030 Store timing: with WAIT_CYCLES = 2, sw 0x12345678 @0x10 -> rsp_valid 3 cycles after acceptance, and req_ready = 0 in between. A following lw @0x10 returns 0x12345678.
REQ-031 Byte access: sb 0x80 @0x13 ->
- lb @0x13 returns 0xFFFFFF80;
- lbu @0x13 returns 0x00000080;
- lw @0x10 returns 0x80345678.
REQ-032 Half access: sh 0xBEEF @0x12 ->
- lw @0x10 returns 0xBEEF5678;
- lh @0x12 returns 0xFFFFBEEF;
- lhu @0x12 returns 0x0000BEEF.
REQ-033 Reset mid-store: reset = 0 during the ACCESS of sw 0xAAAAAAAA @0x20 -> no rsp_valid is produced, req_ready = 1 after release, and lw @0x20 returns 0.
REQ-034 Misaligned load: lw @0x11 ->
- with DM_ALIGN_CHECK_EN: rsp_err = 1, rdata = 0, memory unchanged;
- without DM_ALIGN_CHECK_EN: returns the word at 0x10 with rsp_err = 0.
REQ-035 Wrap and zero wait: with DEPTH_LOG2 = 10 and WAIT_CYCLES = 0, sw 0x5A5A5A5A @0x1000 -> rsp_valid 1 cycle after acceptance. A following lw @0x0 returns 0x5A5A5A5A.
